// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_t;

    localparam int RETRY_W = 2;
    localparam int LOSS_W  = 8;

    // Largest of the four timing parameters; sizes the shared phase counter.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the sequencer and the PLL / downstream reset tree.
// Latency: n/a (wires only).
// Backpressure: none; restart is a single-cycle request that is always accepted.
//
// master: the sequencer (drives PLL reset, system reset and status).
// slave : the surrounding board logic (drives lock and restart).
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_locked;      // PLL LOCK, asynchronous to the sequencer clock
    logic               restart;         // single-cycle request to re-run the sequence
    logic               pll_rst;         // PLL RST, active high
    logic               sys_reset_n;     // active-low reset for PLL-clocked logic
    logic               ready;           // high only in RUN
    logic               fault;           // high only in FAULT
    logic [RETRY_W-1:0] retry_count;     // failed attempts in the current sequence
    logic [LOSS_W-1:0]  lock_loss_count; // lock-loss events seen in RUN

    modport master (
        input  pll_locked, restart,
        output pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_count
    );

    modport slave (
        output pll_locked, restart,
        input  pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser; also used by each PLL domain to release sys_reset_n locally.
// Latency: 2 destination clock edges.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low, output resets to 0), d_i (async input), q_o (synchronised).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification with timeout/retry, and system reset release.
// Latency: outputs registered, change on the state-entry edge; lock seen 2 edges after it moves.
// Backpressure: none; restart is always accepted and wins over any simultaneous event.
//
// Ports: clock (free-running 25 MHz oscillator), reset_n (async active-low),
//        bus (pll_reset_sequencer_if.master: pll_locked, restart in; pll_rst, sys_reset_n,
//        ready, fault, retry_count, lock_loss_count out).
// Build option: define PLL_SEQ_LOSS_COUNT_EN to implement lock_loss_count; otherwise it reads 0.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 250000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pll_reset_sequencer_if.master bus
);

    localparam int CNT_MAX = max_of4(RST_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES, MAX_RETRIES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, sys_reset_n_q, ready_q, fault_q;
    logic               lk;

    sync_2ff u_lock_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d_i   (bus.pll_locked),
        .q_o   (lk)
    );

    // One phase counter serves every state; it is cleared on each state entry,
    // so it only has to reach the largest single-state limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (bus.restart) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (int'(retry_q) >= MAX_RETRIES) begin
                            state_d = FAULT;
                        end else begin
                            state_d = RESET_PLL;
                            retry_d = (&retry_q) ? retry_q : retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    // A dropout restarts the wait; it is not a failed attempt.
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_d = RESET_PLL;
                        cnt_d   = '0;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the entry edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= (state_d == RESET_PLL) || (state_d == FAULT);
            sys_reset_n_q <= (state_d == RUN);
            ready_q       <= (state_d == RUN);
            fault_q       <= (state_d == FAULT);
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic              loss_evt;
    logic [LOSS_W-1:0] loss_q;

    // restart takes the RUN exit first, so it never counts as a lock loss.
    assign loss_evt = !bus.restart && (state_q == RUN) && !lk;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (loss_evt && !(&loss_q)) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign bus.lock_loss_count = loss_q;
`else
    assign bus.lock_loss_count = '0;
`endif

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_reset_n = sys_reset_n_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   n;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .RST_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    localparam int LOSS_ONE = 1;
    localparam int LOSS_SAT = 255;
`else
    localparam int LOSS_ONE = 0;
    localparam int LOSS_SAT = 0;
`endif

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.pll_rst;
            1:       return bus.ready;
            2:       return bus.sys_reset_n;
            default: return bus.fault;
        endcase
    endfunction

    task automatic tick(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Number of edges until the selected output equals val; -1 if the bound expires.
    task automatic wait_for(input int sel, input logic val, input int bound, output int edges);
        int i;
        edges = -1;
        i = 0;
        while (edges < 0 && i < bound) begin
            @(posedge clock);
            #1;
            i++;
            if (sig(sel) === val) edges = i;
        end
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart = 1'b0;
        tick(3);
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b want 1", bus.pll_rst); end
        n_checks++; if (bus.sys_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_reset_n got %b want 0", bus.sys_reset_n); end
        n_checks++; if (bus.ready !== 1'b0 || bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_ready_fault got %b%b want 00", bus.ready, bus.fault); end
        n_checks++; if (bus.retry_count !== 2'd0 || bus.lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.retry_count, bus.lock_loss_count); end
    endtask

    task automatic test_nominal();
        reset_n = 1'b1;
        wait_for(0, 1'b0, 20, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL nominal_pll_rst_len got %0d want 4", n); end
        tick(10);
        bus.pll_locked = 1'b1;
        // 2 sync edges, 1 edge into STABLE, 8 qualifying edges.
        wait_for(1, 1'b1, 30, n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL nominal_ready_delay got %0d want 11", n); end
        n_checks++; if (bus.sys_reset_n !== 1'b1 || bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL nominal_run_outputs got sys=%b rst=%b want 1 0", bus.sys_reset_n, bus.pll_rst); end
        n_checks++; if (bus.retry_count !== 2'd0) begin n_fail++; $display("FAIL nominal_retry got %0d want 0", bus.retry_count); end
    endtask

    task automatic test_glitch();
        bus.pll_locked = 1'b0;
        pulse_restart();
        n_checks++; if (bus.ready !== 1'b0 || bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_restart got ready=%b rst=%b want 0 1", bus.ready, bus.pll_rst); end
        wait_for(0, 1'b0, 20, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL glitch_pll_rst_len got %0d want 4", n); end
        bus.pll_locked = 1'b1;
        tick(6);
        bus.pll_locked = 1'b0;
        tick(3);
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL glitch_no_release got %b want 0", bus.ready); end
        bus.pll_locked = 1'b1;
        wait_for(1, 1'b1, 30, n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL glitch_ready_delay got %0d want 11", n); end
        n_checks++; if (bus.retry_count !== 2'd0) begin n_fail++; $display("FAIL glitch_retry got %0d want 0", bus.retry_count); end
    endtask

    task automatic test_retries_fault();
        bus.pll_locked = 1'b0;
        pulse_restart();
        for (int a = 0; a < 3; a++) begin
            wait_for(0, 1'b0, 20, n);
            n_checks++; if (n !== 4) begin n_fail++; $display("FAIL retry%0d_pulse_len got %0d want 4", a, n); end
            wait_for(0, 1'b1, 60, n);
            n_checks++; if (n !== 32) begin n_fail++; $display("FAIL retry%0d_wait_len got %0d want 32", a, n); end
            if (a < 2) begin
                n_checks++; if (bus.retry_count !== 2'(a + 1)) begin n_fail++; $display("FAIL retry%0d_count got %0d want %0d", a, bus.retry_count, a + 1); end
            end
        end
        n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL fault_entry got %b want 1", bus.fault); end
        tick(100);
        n_checks++; if (bus.fault !== 1'b1 || bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0 || bus.ready !== 1'b0) begin
            n_fail++; $display("FAIL fault_hold got f=%b r=%b s=%b rdy=%b want 1 1 0 0", bus.fault, bus.pll_rst, bus.sys_reset_n, bus.ready);
        end
        n_checks++; if (bus.retry_count !== 2'd2) begin n_fail++; $display("FAIL fault_retry got %0d want 2", bus.retry_count); end
    endtask

    task automatic test_fault_recovery();
        bus.pll_locked = 1'b1;
        tick(3);
        n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL fault_ignores_lock got %b want 1", bus.fault); end
        pulse_restart();
        n_checks++; if (bus.fault !== 1'b0 || bus.retry_count !== 2'd0 || bus.pll_rst !== 1'b1) begin
            n_fail++; $display("FAIL recover_restart got f=%b retry=%0d rst=%b want 0 0 1", bus.fault, bus.retry_count, bus.pll_rst);
        end
        wait_for(0, 1'b0, 20, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL recover_pulse_len got %0d want 4", n); end
        wait_for(1, 1'b1, 30, n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL recover_ready_delay got %0d want 9", n); end
    endtask

    task automatic test_lock_loss();
        int timeouts;
        n_checks++; if (bus.lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL loss_before got %0d want 0", bus.lock_loss_count); end
        bus.pll_locked = 1'b0;
        wait_for(2, 1'b0, 10, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL loss_sys_reset_delay got %0d want 3", n); end
        n_checks++; if (bus.lock_loss_count !== 8'(LOSS_ONE)) begin n_fail++; $display("FAIL loss_count_one got %0d want %0d", bus.lock_loss_count, LOSS_ONE); end
        n_checks++; if (bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL loss_reseq got rst=%b rdy=%b want 1 0", bus.pll_rst, bus.ready); end
        bus.pll_locked = 1'b1;
        wait_for(1, 1'b1, 40, n);
        n_checks++; if (n !== 13) begin n_fail++; $display("FAIL loss_reseq_delay got %0d want 13", n); end
        timeouts = 0;
        for (int it = 0; it < 299; it++) begin
            bus.pll_locked = 1'b0;
            wait_for(1, 1'b0, 10, n);
            if (n < 0) timeouts++;
            bus.pll_locked = 1'b1;
            wait_for(1, 1'b1, 40, n);
            if (n < 0) timeouts++;
        end
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL loss_loop_timeouts got %0d want 0", timeouts); end
        n_checks++; if (bus.lock_loss_count !== 8'(LOSS_SAT)) begin n_fail++; $display("FAIL loss_saturate got %0d want %0d", bus.lock_loss_count, LOSS_SAT); end
    endtask

    task automatic test_async_reset();
        bus.pll_locked = 1'b0;
        wait_for(1, 1'b0, 10, n);
        bus.pll_locked = 1'b1;
        tick(7);
        n_checks++; if (bus.ready !== 1'b0 || bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL areset_pre got rdy=%b rst=%b want 0 0", bus.ready, bus.pll_rst); end
        #5 reset_n = 1'b0;
        #2;
        n_checks++; if (bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0 || bus.ready !== 1'b0 || bus.fault !== 1'b0) begin
            n_fail++; $display("FAIL areset_outputs got r=%b s=%b rdy=%b f=%b want 1 0 0 0", bus.pll_rst, bus.sys_reset_n, bus.ready, bus.fault);
        end
        n_checks++; if (bus.retry_count !== 2'd0 || bus.lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL areset_counts got %0d/%0d want 0/0", bus.retry_count, bus.lock_loss_count); end
        #3 reset_n = 1'b1;
        wait_for(0, 1'b0, 20, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL areset_pulse_len got %0d want 4", n); end
        wait_for(1, 1'b1, 30, n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL areset_ready_delay got %0d want 9", n); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_nominal();
        test_glitch();
        test_retries_fault();
        test_fault_recovery();
        test_lock_loss();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
